// File: rtl/gf163_pkg.sv
// Shared constants and state encoding for the GF(2^163) digit-serial multiplier controller.
package gf163_pkg;

    localparam int GF_M      = 163;
    localparam int GF_DIGITS = 8;
    localparam int GF_NDIG   = (GF_M + GF_DIGITS - 1) / GF_DIGITS;
    localparam int GF_PAD    = GF_NDIG * GF_DIGITS;

    // f(x) = x^163 + x^7 + x^6 + x^3 + 1, hard-wired into the PE array datapath
    localparam logic [GF_M:0] GF_POLY = {1'b1, 155'b0, 8'hC9};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } gf_state_t;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/gf163_bdigit_shift.sv
// Loadable left-shift register presenting operand b one digit at a time, most significant digit first.
module gf163_bdigit_shift #(
    parameter int W_TOTAL = 168,
    parameter int DIGITS  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_load,
    input  logic [W_TOTAL-1:0] i_data,
    input  logic               i_shift,
    output logic [DIGITS-1:0]  o_digit
);

    logic [W_TOTAL-1:0] r_sreg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sreg <= '0;
        end else if (i_load) begin
            r_sreg <= i_data;
        end else if (i_shift) begin
            r_sreg <= {r_sreg[W_TOTAL-DIGITS-1:0], {DIGITS{1'b0}}};
        end
    end

    assign o_digit = r_sreg[W_TOTAL-1 -: DIGITS];

endmodule

// File: rtl/gf_mul_ctrl.sv
// Sequencer for a digit-serial GF(2^163) PE array: loads operands, streams b digits, captures the product.
module gf_mul_ctrl
    import gf163_pkg::*;
#(
    parameter int M        = GF_M,
    parameter int DIGITS   = GF_DIGITS,
    parameter int PIPE_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_in,
    input  logic [M-1:0]      a_in,
    input  logic [M-1:0]      b_in,
    input  logic [M-1:0]      t_in,
    output logic [M-1:0]      a_out,
    output logic [DIGITS-1:0] b_digit_out,
    output logic              pe_clr_out,
    output logic              pe_en_out,
    output logic              busy_out,
    output logic              done_out,
    output logic [M-1:0]      c_out
);

    localparam int NDIG    = ceil_div(M, DIGITS);
    localparam int PAD     = NDIG * DIGITS;
    localparam int CNT_MAX = (NDIG > 8) ? NDIG : 8;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    gf_state_t          r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [M-1:0]       r_a;
    logic [M-1:0]       r_c;
    logic               r_busy;
    logic               r_done;
    logic               r_pe_en;
    logic               r_pe_clr;

    logic               w_accept;
    logic [PAD-1:0]     w_b_pad;
    logic [DIGITS-1:0]  w_digit;

    assign w_accept = start_in && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_b_pad  = {{(PAD - M){1'b0}}, b_in};

    gf163_bdigit_shift #(
        .W_TOTAL (PAD),
        .DIGITS  (DIGITS)
    ) u_bdigit (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_accept),
        .i_data  (w_b_pad),
        .i_shift (r_pe_en),
        .o_digit (w_digit)
    );

    // NOTE: every control output is a flop set on the edge entering its state, so the PE array never sees decode glitches.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_a      <= '0;
            r_c      <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pe_en  <= 1'b0;
            r_pe_clr <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_done <= 1'b0;
                    if (w_accept) begin
                        r_a      <= a_in;
                        r_state  <= ST_LOAD;
                        r_busy   <= 1'b1;
                        r_pe_clr <= 1'b1;
                    end else begin
                        r_state  <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    r_state  <= ST_RUN;
                    r_cnt    <= '0;
                    r_pe_clr <= 1'b0;
                    r_pe_en  <= 1'b1;
                end
                ST_RUN: begin
                    if (r_cnt == CNT_W'(NDIG - 1)) begin
                        r_pe_en <= 1'b0;
                        r_cnt   <= '0;
                        if (PIPE_LAT == 0) begin
                            r_c     <= t_in;
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_DRAIN;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // Wait out the array's pipeline so t_in reflects the final digit
                    if (r_cnt == CNT_W'(PIPE_LAT - 1)) begin
                        r_c     <= t_in;
                        r_cnt   <= '0;
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b0;
                    r_pe_en  <= 1'b0;
                    r_pe_clr <= 1'b0;
                end
            endcase
        end
    end

    assign a_out       = r_a;
    assign b_digit_out = r_pe_en ? w_digit : '0;
    assign pe_clr_out  = r_pe_clr;
    assign pe_en_out   = r_pe_en;
    assign busy_out    = r_busy;
    assign done_out    = r_done;
    assign c_out       = r_c;

endmodule

// File: tb/tb_gf_mul_ctrl.sv
// Scoreboard bench for gf_mul_ctrl driving a behavioural digit-serial PE array with one cycle of latency.
module tb_gf_mul_ctrl;

    localparam int M      = 163;
    localparam int DIGITS = 8;
    localparam int NDIG   = 21;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start_in = 1'b0;
    logic [M-1:0]      a_in = '0;
    logic [M-1:0]      b_in = '0;
    logic [M-1:0]      t_in;
    logic [M-1:0]      a_out;
    logic [DIGITS-1:0] b_digit_out;
    logic              pe_clr_out;
    logic              pe_en_out;
    logic              busy_out;
    logic              done_out;
    logic [M-1:0]      c_out;

    gf_mul_ctrl #(.M(M), .DIGITS(DIGITS), .PIPE_LAT(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_in    (start_in),
        .a_in        (a_in),
        .b_in        (b_in),
        .t_in        (t_in),
        .a_out       (a_out),
        .b_digit_out (b_digit_out),
        .pe_clr_out  (pe_clr_out),
        .pe_en_out   (pe_en_out),
        .busy_out    (busy_out),
        .done_out    (done_out),
        .c_out       (c_out)
    );

    always #5 clk = ~clk;

    // Behavioural PE array: acc <- acc * x^DIGITS + a * digit (mod f), registered once
    localparam logic [M-1:0] POLY_LOW = 163'hC9;
    logic [M-1:0] acc = '0;

    function automatic logic [M-1:0] pe_step(input logic [M-1:0] t, input logic [M-1:0] a,
                                             input logic [DIGITS-1:0] d);
        logic [M-1:0] r;
        logic         msb;
        r = t;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            msb = r[M-1];
            r   = r << 1;
            if (msb) r = r ^ POLY_LOW;
            if (d[i]) r = r ^ a;
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (pe_clr_out) acc <= '0;
        else if (pe_en_out) acc <= pe_step(acc, a_out, b_digit_out);
    end
    assign t_in = acc;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [M-1:0]      exp_q[$];
    logic [DIGITS-1:0] dig_q[$];

    task automatic check(input string name, input logic [M-1:0] act, input logic [M-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest queued product
    always @(negedge clk) begin
        if (done_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done: got done_out=1 expected no pending product");
            end else begin
                check("c_out", c_out, exp_q.pop_front());
            end
        end
        if (pe_en_out === 1'b1) dig_q.push_back(b_digit_out);
    end

    int           inj_cyc = -1;
    int           rst_cyc = -1;
    bit           b2b = 1'b0;
    logic [M-1:0] inj_a, inj_b, b2_a, b2_b, b2_exp;
    logic [M-1:0] one = 1;

    task automatic launch(input logic [M-1:0] a, input logic [M-1:0] b,
                          input logic [M-1:0] exp, input bit push);
        @(posedge clk);
        #1;
        start_in = 1'b1;
        a_in     = a;
        b_in     = b;
        if (push) exp_q.push_back(exp);
        dig_q.delete();
        @(posedge clk);
        #1;
        start_in = 1'b0;
        a_in     = '0;
        b_in     = '0;
    endtask

    // Cycle 1 is the first cycle after the one in which start_in was sampled
    task automatic wait_op(input int budget, output int dc, output int clr,
                           output int en, output int bsy);
        dc = -1; clr = -1; en = 0; bsy = 0;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(negedge clk);
            if (pe_clr_out && clr < 0) clr = cyc;
            if (pe_en_out) en++;
            if (busy_out) bsy++;
            if (cyc == inj_cyc) begin
                start_in = 1'b1;
                a_in     = inj_a;
                b_in     = inj_b;
            end else if (cyc == inj_cyc + 1) begin
                start_in = 1'b0;
            end
            if (cyc == rst_cyc) rst_n = 1'b0;
            if (done_out) begin
                dc = cyc;
                if (b2b) begin
                    start_in = 1'b1;
                    a_in     = b2_a;
                    b_in     = b2_b;
                    exp_q.push_back(b2_exp);
                    dig_q.delete();
                end
                break;
            end
        end
    endtask

    task automatic check_digits(input string tag, input logic [DIGITS-1:0] first,
                                input logic [DIGITS-1:0] mid, input logic [DIGITS-1:0] last);
        bit ok;
        check({tag, "_ndigits"}, M'(dig_q.size()), M'(NDIG));
        if (dig_q.size() == NDIG) begin
            check({tag, "_digit0"}, M'(dig_q[0]), M'(first));
            ok = 1'b1;
            for (int i = 1; i < NDIG - 1; i++) if (dig_q[i] !== mid) ok = 1'b0;
            check({tag, "_digits_mid"}, M'(ok), M'(1));
            check({tag, "_digit_last"}, M'(dig_q[NDIG-1]), M'(last));
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"},   M'(busy_out),    '0);
        check({tag, "_done"},   M'(done_out),    '0);
        check({tag, "_pe_en"},  M'(pe_en_out),   '0);
        check({tag, "_pe_clr"}, M'(pe_clr_out),  '0);
        check({tag, "_bdigit"}, M'(b_digit_out), '0);
        check({tag, "_a_out"},  a_out,           '0);
        check({tag, "_c_out"},  c_out,           '0);
    endtask

    initial begin
        int dc, clr, en, bsy, ndone;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // a=1, b=1: product 1, digits 0x00 x20 then 0x01
        launch(one, one, one, 1'b1);
        wait_op(40, dc, clr, en, bsy);
        check("t1_done_cycle", M'(dc), M'(24));
        check("t1_clr_cycle",  M'(clr), M'(1));
        check("t1_pe_en_cnt",  M'(en), M'(NDIG));
        check("t1_busy_cnt",   M'(bsy), M'(NDIG + 2));
        check_digits("t1", 8'h00, 8'h00, 8'h01);

        // a=x^162, b=x: wraps through f(x) to 0xC9
        launch(one << 162, one << 1, 163'hC9, 1'b1);
        wait_op(40, dc, clr, en, bsy);
        check("t2_done_cycle", M'(dc), M'(24));
        @(negedge clk);
        check("t2_done_width", M'(done_out), '0);
        check("t2_idle_busy",  M'(busy_out), '0);

        // b with all 163 bits set: top digit carries only the 3 live bits
        launch(one, {M{1'b1}}, {M{1'b1}}, 1'b1);
        wait_op(40, dc, clr, en, bsy);
        check("t3_pe_en_cnt", M'(en), M'(NDIG));
        check_digits("t3", 8'h07, 8'hFF, 8'hFF);

        // A second start while busy must leave operands and timing untouched
        inj_cyc = 10;
        inj_a   = one << 2;
        inj_b   = one << 3;
        launch(one, one << 5, 163'h20, 1'b1);
        wait_op(40, dc, clr, en, bsy);
        inj_cyc = -1;
        start_in = 1'b0;
        check("t4_done_cycle", M'(dc), M'(24));
        check("t4_a_out_held", a_out, one);

        // Reset in RUN cycle 12 abandons the operation without a done pulse
        rst_cyc = 12;
        launch(one << 100, one << 10, '0, 1'b0);
        wait_op(12, dc, clr, en, bsy);
        rst_cyc = -1;
        @(negedge clk);
        check_quiet("midreset");
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done_out) ndone++;
        end
        check("t5_no_done", M'(ndone), '0);
        launch(one << 100, one << 10, one << 110, 1'b1);
        wait_op(40, dc, clr, en, bsy);
        check("t5_restart_done_cycle", M'(dc), M'(24));

        // Back-to-back: start in the DONE cycle goes straight to LOAD
        b2b    = 1'b1;
        b2_a   = one << 162;
        b2_b   = one << 2;
        b2_exp = 163'h192;
        launch(one << 81, one << 81, one << 162, 1'b1);
        wait_op(40, dc, clr, en, bsy);
        b2b = 1'b0;
        check("t6a_done_cycle", M'(dc), M'(24));
        check("t6a_busy_cnt",   M'(bsy), M'(NDIG + 2));
        check("t6_gap_busy",    M'(busy_out), '0);
        @(posedge clk);
        #1;
        start_in = 1'b0;
        a_in     = '0;
        b_in     = '0;
        wait_op(40, dc, clr, en, bsy);
        check("t6b_clr_cycle",  M'(clr), M'(1));
        check("t6b_done_cycle", M'(dc), M'(24));
        check("t6b_busy_cnt",   M'(bsy), M'(NDIG + 2));

        repeat (4) @(negedge clk);
        check("scoreboard_drained", M'(exp_q.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/gf_mul_ctrl.md
GF_MUL_CTRL -- requirements
Module: gf_mul_ctrl

Interface
REQ-001 SHALL have parameter M, default 163: field degree; f(x)=x^163+x^7+x^6+x^3+1 is fixed in the datapath.
REQ-002 SHALL have parameter DIGITS, default 8: b-digit width consumed per PE-array step.
REQ-003 SHALL have parameter PIPE_LAT, default 1, legal range 0..7: cycles from the last digit fed to t_in being valid.
REQ-004 SHALL have port clk  input  1  sole clock; all logic is rising-edge.
REQ-005 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have port start_in  input  1  request a multiplication; a_in and b_in are sampled in the same cycle.
REQ-007 SHALL have port a_in  input  M  operand a.
REQ-008 SHALL have port b_in  input  M  operand b.
REQ-009 SHALL have port t_in  input  M  reduced result from the PE array.
REQ-010 SHALL have port a_out  input-held output  M  registered operand a, driven to the PE array.
REQ-011 SHALL have port b_digit_out  output  DIGITS  current b digit, MSB-first.
REQ-012 SHALL have port pe_clr_out  output  1  clears the array accumulator.
REQ-013 SHALL have port pe_en_out  output  1  advances the array one digit step.
REQ-014 SHALL have port busy_out  output  1  operation in progress.
REQ-015 SHALL have port done_out  output  1  one-cycle pulse; c_out is valid.
REQ-016 SHALL have port c_out  output  M  registered product, held until the next capture.

Function
REQ-017 SHALL define NDIG = ceil(M/DIGITS) (21 at defaults); b is zero-padded at the MSB end to NDIG*DIGITS bits (168 at defaults).
REQ-018 SHALL implement states IDLE, LOAD, RUN, DRAIN, DONE.
REQ-019 SHALL, in IDLE or DONE with start_in=1 at cycle 0, register a_in and b_in and enter LOAD at cycle 1.
REQ-020 SHALL, in LOAD, assert pe_clr_out=1 for exactly one cycle with pe_en_out=0, then enter RUN.
REQ-021 SHALL hold RUN for exactly NDIG cycles (cycles 2..NDIG+1), with pe_en_out=1 and b_digit_out = padded digit k (k=0 first = most significant), k counting 0..NDIG-1.
REQ-022 SHALL hold DRAIN for PIPE_LAT cycles with pe_en_out=0; DRAIN is skipped when PIPE_LAT=0.
REQ-023 SHALL capture t_in into c_out on the clock edge leaving the last RUN/DRAIN cycle, and assert done_out=1 in DONE (cycle NDIG+2+PIPE_LAT; 24 at defaults) for exactly one cycle.
REQ-024 SHALL assert busy_out=1 in LOAD, RUN and DRAIN only, and busy_out=0 in IDLE and DONE.
REQ-025 SHALL ignore start_in while busy_out=1: no re-sampling of operands and no change to the sequence.
REQ-026 SHALL, in DONE, go to LOAD if start_in=1 (back-to-back operation, operands sampled then); otherwise go to IDLE.
REQ-027 SHALL drive b_digit_out=0 outside RUN.
REQ-028 SHALL keep a_out stable from LOAD through the end of DRAIN.

Reset
REQ-029 SHALL, while rst_n=0 at a clock edge, force: state=IDLE, digit counter=0, a_out=0, b register=0, c_out=0, and busy_out, done_out, pe_en_out, pe_clr_out all 0.
REQ-030 SHALL, on reset asserted mid-operation, abandon the operation with no done_out pulse, and start a fresh LOAD on the first accepted start_in after reset.

Structure
REQ-031 SHALL place M, DIGITS, NDIG, the state enumeration and the f(x) constant in shared package gf163_pkg.
REQ-032 SHALL contain one sub-module, gf163_bdigit_shift: a loadable left-shift register of NDIG*DIGITS bits that outputs its top DIGITS bits and shifts by DIGITS when pe_en_out=1.
REQ-033 SHALL keep the counter, FSM and c_out register in gf_mul_ctrl; no arithmetic on a or t is performed in this block.

Verification (bench drives a golden-model PE array with PIPE_LAT=1)
REQ-034 SHALL cover: a=1, b=1, start at cycle 0 -> pe_clr at cycle 1; digits 0x00 x20 then 0x01; done at cycle 24 with c_out=1.
REQ-035 SHALL cover: a=x^162, b=x -> c_out=0xC9 (x^7+x^6+x^3+1); done held for 1 cycle only.
REQ-036 SHALL cover: b = all 163 bits set -> digit 0 = 0x07, digits 1..20 = 0xFF; exactly 21 pe_en_out cycles.
REQ-037 SHALL cover: start_in pulsed with different operands at cycle 10 -> ignored; c_out matches the cycle-0 operands.
REQ-038 SHALL cover: rst_n=0 during RUN cycle 12 -> all outputs 0 next cycle, no done; restart produces the correct product.
REQ-039 SHALL cover: start_in=1 in the DONE cycle -> LOAD next cycle, busy_out low for exactly one cycle between operations, both products correct.
